id_ex_hazard_ctrl: RTL and testbench
====================================

// Module: id_ex_hazard_ctrl
// PURPOSE
//  Control partner of the ID/EX pipeline register. It reads what that register presents in EX
//  (Rd_ex, MemtoReg_ex, RegWrite_ex) and the source registers of the instruction now in ID.
//  It drives the stall, bubble and flush controls back into PC, IF/ID and the ID/EX register.
//  Sequential parts: load-use stall FSM, multi-cycle branch-flush counter, saturating perf counters.
// PARAMETERS
//  FLUSH_CYCLES  1   cycles IF/ID is flushed after a taken branch resolves in EX (1..7)
//  CNT_W         32  width of the stall_count and flush_count performance counters
//  ZERO_REG      31  register index of XZR; never a hazard source or target
// PORTS
//  clk             in   1      clock, rising edge
//  reset           in   1      asynchronous, active-high
//  Rn_id           in   5      first source register of the instruction in ID
//  Ab_id           in   5      second source register (Rm/Rt) of the instruction in ID
//  uses_rn_id      in   1      instruction in ID reads Rn
//  uses_ab_id      in   1      instruction in ID reads Ab
//  Rd_ex           in   5      destination register of the instruction in EX (ID/EX output)
//  MemtoReg_ex     in   1      instruction in EX is a load (ID/EX output)
//  RegWrite_ex     in   1      instruction in EX writes the register file (ID/EX output)
//  branch_taken_ex in   1      branch in EX resolved taken this cycle
//  pc_write        out  1      1 = PC may update
//  if_id_write     out  1      1 = IF/ID may load
//  id_ex_bubble    out  1      1 = ID/EX loads zeros into all control fields (RegWrite, MemWrite, branch, ...)
//  if_id_flush     out  1      1 = IF/ID loads a NOP
//  stall_count     out  CNT_W  number of load-use stall cycles, saturating
//  flush_count     out  CNT_W  number of flush cycles, saturating
// BEHAVIOUR
//  - load_use = MemtoReg_ex & RegWrite_ex & Rd_ex!=ZERO_REG &
//    ((uses_rn_id & Rn_id==Rd_ex) | (uses_ab_id & Ab_id==Rd_ex)).
//  - States: RUN, LOAD_STALL, FLUSH. Reset state is RUN; reset is async.
//  - Control outputs are Mealy. They act in the same cycle as detection so the PC freezes with zero latency.
//  - RUN, branch_taken_ex=1 (wins over load_use):
//    - this cycle: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1.
//    - if FLUSH_CYCLES>1: go to FLUSH, remaining counter := FLUSH_CYCLES-1; otherwise stay in RUN.
//  - RUN, load_use=1 and no branch:
//    - this cycle: pc_write=0, if_id_write=0, id_ex_bubble=1.
//    - go to LOAD_STALL.
//  - RUN, neither event: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0.
//  - LOAD_STALL: exactly one cycle, with all outputs at their RUN idle values.
//    - load_use is not evaluated here; the bubble guarantees MemtoReg_ex=0 and MEM->EX forwarding supplies the data.
//    - A branch_taken_ex arriving here is handled as in RUN.
//    - Next state is RUN (or FLUSH, by the RUN branch rule).
//  - FLUSH:
//    - each cycle: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1; load_use is ignored.
//    - counter decrements each cycle; leave for RUN in the cycle it reaches 0.
//    - a new branch_taken_ex reloads the counter to FLUSH_CYCLES-1.
//  - While reset is high: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=1, state=RUN,
//    counters=0, stall_count=0, flush_count=0.
//  - stall_count increments in every cycle with pc_write=0 and reset low.
//  - flush_count increments in every cycle with if_id_flush=1 and reset low.
//  - Both perf counters hold at 2^CNT_W-1 (saturate, never wrap).
//  - Reset asserted mid-stall or mid-flush: outputs take their reset values immediately.
//    After reset, operation resumes in RUN with no residual stall or flush.
// STRUCTURE
//  - cpu_pkg: typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH} hazard_state_t; localparam XZR = 5'd31.
//  - One sub-module, sat_counter #(W): inc, clk, reset -> count. Instantiated twice (stall, flush).
//  - FSM uses one always_ff (state and flush counter) plus one always_comb (next state and outputs).
// TESTING
//  1. LDUR X3 in EX (Rd_ex=3, MemtoReg_ex=1, RegWrite_ex=1), ADD in ID with Rn_id=3, uses_rn_id=1
//     -> 1 cycle with pc_write=0 and id_ex_bubble=1, then RUN; stall_count=1.
//  2. Same as 1 but Rd_ex=31, or uses_rn_id=0, or MemtoReg_ex=0 -> no stall, all outputs idle.
//  3. branch_taken_ex and load_use high together, FLUSH_CYCLES=2 -> if_id_flush=1 for 2 cycles,
//     pc_write stays 1, no stall; flush_count=2.
//  4. Reset asserted in the LOAD_STALL cycle and in FLUSH -> outputs take reset values
//     asynchronously, before the next edge; after release, RUN with idle outputs and counters=0.
//  5. CNT_W=4, 20 back-to-back load-use pairs -> stall_count saturates at 15 and holds.
//  6. Random ID/EX register streams vs. reference model -> never two consecutive pc_write=0 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the ID/EX hazard control slice.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    FLUSH
  } hazard_state_t;

  localparam logic [4:0] XZR = 5'd31;

  // A load in EX whose destination is read by the instruction in ID; XZR never carries a dependency.
  function automatic logic isLoadUse(
    input logic [4:0] rnId,
    input logic [4:0] abId,
    input logic       usesRn,
    input logic       usesAb,
    input logic [4:0] rdEx,
    input logic       memToRegEx,
    input logic       regWriteEx,
    input logic [4:0] zeroReg
  );
    return memToRegEx && regWriteEx && (rdEx != zeroReg) &&
           ((usesRn && (rnId == rdEx)) || (usesAb && (abId == rdEx)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         inc,
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Advance on request but stick at all-ones so the count never wraps back to a small value.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Counter register, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// Stall/bubble/flush control for the ID/EX pipeline register: load-use stall FSM,
// multi-cycle branch flush and saturating stall/flush performance counters.
module id_ex_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int         FLUSH_CYCLES = 1,
  parameter int         CNT_W        = 32,
  parameter logic [4:0] ZERO_REG     = XZR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rn_id,
  input  logic [4:0]       Ab_id,
  input  logic             uses_rn_id,
  input  logic             uses_ab_id,
  input  logic [4:0]       Rd_ex,
  input  logic             MemtoReg_ex,
  input  logic             RegWrite_ex,
  input  logic             branch_taken_ex,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  hazard_state_t state_q;
  hazard_state_t state_d;
  logic [2:0]    flushCnt_q;
  logic [2:0]    flushCnt_d;
  logic          loadUse;
  logic          stallInc;
  logic          flushInc;

  assign loadUse = isLoadUse(Rn_id, Ab_id, uses_rn_id, uses_ab_id,
                             Rd_ex, MemtoReg_ex, RegWrite_ex, ZERO_REG);

  // Mealy next-state and control outputs; a taken branch always beats a load-use stall,
  // and reset forces the safe freeze/flush pattern without waiting for a clock edge.
  always_comb begin
    state_d      = state_q;
    flushCnt_d   = flushCnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;

    case (state_q)
      RUN, LOAD_STALL: begin
        if (branch_taken_ex) begin
          id_ex_bubble = 1'b1;
          if_id_flush  = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d    = FLUSH;
            flushCnt_d = FLUSH_RELOAD;
          end else begin
            state_d    = RUN;
            flushCnt_d = '0;
          end
        end else if ((state_q == RUN) && loadUse) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          state_d      = LOAD_STALL;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        id_ex_bubble = 1'b1;
        if_id_flush  = 1'b1;
        if (branch_taken_ex) begin
          flushCnt_d = FLUSH_RELOAD;
        end else if (flushCnt_q <= 3'd1) begin
          state_d    = RUN;
          flushCnt_d = '0;
        end else begin
          flushCnt_d = flushCnt_q - 3'd1;
        end
      end
      default: begin
        state_d    = RUN;
        flushCnt_d = '0;
      end
    endcase

    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end
  end

  // State and remaining-flush register; reset returns to RUN with nothing pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign stallInc = ~pc_write & ~reset;
  assign flushInc = if_id_flush & ~reset;

  sat_counter #(.W(CNT_W)) u_stallCounter (
    .inc   (stallInc),
    .clk   (clk),
    .reset (reset),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flushCounter (
    .inc   (flushInc),
    .clk   (clk),
    .reset (reset),
    .count (flush_count)
  );

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Directed and model-checked bench for id_ex_hazard_ctrl.
// Control outputs are compared as {pc_write, if_id_write, id_ex_bubble, if_id_flush}.
module tb_id_ex_hazard_ctrl;

   localparam logic [3:0] CTRL_RESET = 4'b0011;
   localparam logic [3:0] CTRL_IDLE  = 4'b1100;
   localparam logic [3:0] CTRL_STALL = 4'b0010;
   localparam logic [3:0] CTRL_FLUSH = 4'b1111;

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] rnId, abId, rdEx;
   logic       usesRn, usesAb, memToRegEx, regWriteEx, branchTaken;

   logic        pcWrite, ifIdWrite, idExBubble, ifIdFlush;
   logic [3:0]  stallCount, flushCount;
   logic        pcWrite1, ifIdWrite1, idExBubble1, ifIdFlush1;
   logic [31:0] stallCount1, flushCount1;
   logic [3:0]  ctrl, ctrl1;

   int errors = 0;
   int checks = 0;

   assign ctrl  = {pcWrite, ifIdWrite, idExBubble, ifIdFlush};
   assign ctrl1 = {pcWrite1, ifIdWrite1, idExBubble1, ifIdFlush1};

   always #5 clock = ~clock;

   id_ex_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
      .clk(clock), .reset(reset),
      .Rn_id(rnId), .Ab_id(abId), .uses_rn_id(usesRn), .uses_ab_id(usesAb),
      .Rd_ex(rdEx), .MemtoReg_ex(memToRegEx), .RegWrite_ex(regWriteEx),
      .branch_taken_ex(branchTaken),
      .pc_write(pcWrite), .if_id_write(ifIdWrite), .id_ex_bubble(idExBubble),
      .if_id_flush(ifIdFlush), .stall_count(stallCount), .flush_count(flushCount)
   );

   id_ex_hazard_ctrl dutDefault (
      .clk(clock), .reset(reset),
      .Rn_id(rnId), .Ab_id(abId), .uses_rn_id(usesRn), .uses_ab_id(usesAb),
      .Rd_ex(rdEx), .MemtoReg_ex(memToRegEx), .RegWrite_ex(regWriteEx),
      .branch_taken_ex(branchTaken),
      .pc_write(pcWrite1), .if_id_write(ifIdWrite1), .id_ex_bubble(idExBubble1),
      .if_id_flush(ifIdFlush1), .stall_count(stallCount1), .flush_count(flushCount1)
   );

   // Counts every comparison and reports any difference between observed and expected.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drives one set of ID/EX inputs and lets the combinational outputs settle.
   task automatic applyStimulus(input logic [4:0] rn, input logic [4:0] ab, input logic uRn, input logic uAb,
                                input logic [4:0] rd, input logic mtr, input logic rw, input logic br);
      rnId = rn; abId = ab; usesRn = uRn; usesAb = uAb;
      rdEx = rd; memToRegEx = mtr; regWriteEx = rw; branchTaken = br;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic applyIdle();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // LDUR X3 in EX feeding an ADD that reads X3 as Rn.
   task automatic applyLoadUse(input logic br);
      applyStimulus(5'd3, 5'd9, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, br);
   endtask

   task automatic doReset();
      reset = 1'b1;
      nextCycle();
      reset = 1'b0;
      applyIdle();
   endtask

   // Reference model state for the random phase.
   int         mState;
   int         mCnt;
   int         mStalls;
   int         mFlushes;
   logic [3:0] mCtrl;
   logic       prevStall;
   logic       mLoadUse;

   function automatic logic [4:0] pickReg(input int sel);
      case (sel)
         0:       return 5'd3;
         1:       return 5'd5;
         2:       return 5'd31;
         default: return 5'd7;
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      applyIdle();

      // Reset state, visible before the first clock edge.
      checkOutput("resetCtrl", 32'(ctrl), 32'(CTRL_RESET));
      checkOutput("resetStallCnt", 32'(stallCount), 32'd0);
      checkOutput("resetFlushCnt", 32'(flushCount), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      applyIdle();
      checkOutput("idleAfterReset", 32'(ctrl), 32'(CTRL_IDLE));

      // Load-use through Rn: one stall cycle, then idle even with the load still shown in EX.
      applyLoadUse(1'b0);
      checkOutput("loadUseRn", 32'(ctrl), 32'(CTRL_STALL));
      nextCycle();
      checkOutput("loadStallIdle", 32'(ctrl), 32'(CTRL_IDLE));
      checkOutput("stallCnt1", 32'(stallCount), 32'd1);
      applyIdle();
      nextCycle();
      checkOutput("backToRun", 32'(ctrl), 32'(CTRL_IDLE));
      checkOutput("stallCntHold", 32'(stallCount), 32'd1);

      // Near misses: XZR target, unused Rn, not a load, no register write.
      applyStimulus(5'd31, 5'd9, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0);
      checkOutput("noStallXzr", 32'(ctrl), 32'(CTRL_IDLE));
      applyStimulus(5'd3, 5'd9, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
      checkOutput("noStallUnusedRn", 32'(ctrl), 32'(CTRL_IDLE));
      applyStimulus(5'd3, 5'd9, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
      checkOutput("noStallNotLoad", 32'(ctrl), 32'(CTRL_IDLE));
      applyStimulus(5'd3, 5'd9, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
      checkOutput("noStallNoWrite", 32'(ctrl), 32'(CTRL_IDLE));
      nextCycle();
      checkOutput("stallCntNearMiss", 32'(stallCount), 32'd1);

      // Load-use through the second source.
      applyStimulus(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
      checkOutput("loadUseAb", 32'(ctrl), 32'(CTRL_STALL));
      nextCycle();
      applyIdle();
      checkOutput("loadUseAbRelease", 32'(ctrl), 32'(CTRL_IDLE));
      checkOutput("stallCnt2", 32'(stallCount), 32'd2);

      // Branch and load-use together: branch wins, two flush cycles, no stall.
      doReset();
      applyLoadUse(1'b1);
      checkOutput("branchWins", 32'(ctrl), 32'(CTRL_FLUSH));
      checkOutput("branchWinsFc1", 32'(ctrl1), 32'(CTRL_FLUSH));
      nextCycle();
      applyLoadUse(1'b0);
      checkOutput("flushSecondCycle", 32'(ctrl), 32'(CTRL_FLUSH));
      checkOutput("fc1StallAfterBranch", 32'(ctrl1), 32'(CTRL_STALL));
      nextCycle();
      applyIdle();
      checkOutput("flushDone", 32'(ctrl), 32'(CTRL_IDLE));
      checkOutput("flushCnt2", 32'(flushCount), 32'd2);
      checkOutput("stallCntNoStall", 32'(stallCount), 32'd0);
      checkOutput("flushCntFc1", flushCount1, 32'd1);
      checkOutput("stallCntFc1", stallCount1, 32'd1);

      // A second taken branch during FLUSH restarts the flush window.
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      nextCycle();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("reloadBranch", 32'(ctrl), 32'(CTRL_FLUSH));
      nextCycle();
      applyIdle();
      checkOutput("reloadTail", 32'(ctrl), 32'(CTRL_FLUSH));
      nextCycle();
      checkOutput("reloadDone", 32'(ctrl), 32'(CTRL_IDLE));
      checkOutput("flushCnt5", 32'(flushCount), 32'd5);

      // Taken branch arriving in the LOAD_STALL cycle.
      applyLoadUse(1'b0);
      nextCycle();
      applyLoadUse(1'b1);
      checkOutput("branchInLoadStall", 32'(ctrl), 32'(CTRL_FLUSH));
      nextCycle();
      applyIdle();
      checkOutput("flushAfterLoadStall", 32'(ctrl), 32'(CTRL_FLUSH));
      nextCycle();
      checkOutput("idleAfterLsFlush", 32'(ctrl), 32'(CTRL_IDLE));

      // Reset raised in the LOAD_STALL cycle acts before the next edge.
      applyLoadUse(1'b0);
      nextCycle();
      reset = 1'b1;
      #1;
      checkOutput("resetInStall", 32'(ctrl), 32'(CTRL_RESET));
      checkOutput("resetInStallCnt", 32'(stallCount), 32'd0);
      checkOutput("resetInStallFlushCnt", 32'(flushCount), 32'd0);
      nextCycle();
      reset = 1'b0;
      applyIdle();
      checkOutput("afterStallReset", 32'(ctrl), 32'(CTRL_IDLE));
      nextCycle();
      checkOutput("afterStallResetRun", 32'(ctrl), 32'(CTRL_IDLE));
      checkOutput("afterStallResetCnt", 32'(stallCount), 32'd0);

      // Reset raised during FLUSH.
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      nextCycle();
      applyIdle();
      checkOutput("inFlushBeforeReset", 32'(ctrl), 32'(CTRL_FLUSH));
      reset = 1'b1;
      #1;
      checkOutput("resetInFlush", 32'(ctrl), 32'(CTRL_RESET));
      checkOutput("resetInFlushCnt", 32'(flushCount), 32'd0);
      nextCycle();
      reset = 1'b0;
      applyIdle();
      checkOutput("afterFlushReset", 32'(ctrl), 32'(CTRL_IDLE));
      nextCycle();
      checkOutput("afterFlushResetRun", 32'(ctrl), 32'(CTRL_IDLE));
      checkOutput("afterFlushResetCnt", 32'(flushCount), 32'd0);

      // Twenty back-to-back load-use pairs: the 4-bit counter saturates at 15.
      doReset();
      applyLoadUse(1'b0);
      for (int i = 0; i < 28; i++) nextCycle();
      checkOutput("stallCnt14", 32'(stallCount), 32'd14);
      for (int i = 0; i < 12; i++) nextCycle();
      checkOutput("stallCntSat", 32'(stallCount), 32'd15);
      checkOutput("stallCntWide", stallCount1, 32'd20);

      // Random ID/EX streams against a reference model.
      doReset();
      mState = 0; mCnt = 0; mStalls = 0; mFlushes = 0; prevStall = 1'b0;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(pickReg(int'($urandom_range(0, 3))), pickReg(int'($urandom_range(0, 3))),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       pickReg(int'($urandom_range(0, 3))), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
         mLoadUse = memToRegEx && regWriteEx && (rdEx != 5'd31) &&
                    ((usesRn && rnId == rdEx) || (usesAb && abId == rdEx));
         if (mState == 2) begin
            mCtrl = CTRL_FLUSH;
            if (branchTaken) mCnt = 1;
            else if (mCnt <= 1) begin mState = 0; mCnt = 0; end
            else mCnt = mCnt - 1;
         end else if (branchTaken) begin
            mCtrl = CTRL_FLUSH;
            mState = 2; mCnt = 1;
         end else if (mState == 0 && mLoadUse) begin
            mCtrl = CTRL_STALL;
            mState = 1;
         end else begin
            mCtrl = CTRL_IDLE;
            mState = 0;
         end
         checkOutput("randomCtrl", 32'(ctrl), 32'(mCtrl));
         checkOutput("noDoubleStall", 32'(prevStall & ~pcWrite), 32'd0);
         prevStall = ~pcWrite;
         if (!mCtrl[3] && mStalls < 15) mStalls++;
         if (mCtrl[0] && mFlushes < 15) mFlushes++;
         nextCycle();
      end
      checkOutput("randomStallCnt", 32'(stallCount), 32'(mStalls));
      checkOutput("randomFlushCnt", 32'(flushCount), 32'(mFlushes));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
